ddr3_cmd_arbiter: RTL and testbench
===================================

Name: ddr3_cmd_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the single CPU-to-controller command/data channel (ADDR_VALID/CMD/BA/ADDR/WR_DATA, CMD_RDY/WR_DATA_VALID) between NUM_REQ traffic sources.
- Sits between the traffic generators and the DDR3 controller front end.
- Grants one requester at a time, forwards its command, and steers the 16-word burst data in either direction.
- Releases the channel only after the full burst has completed.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 15, address width (row address).
- BA_W, 3, bank address width.
- DATA_W, 64, data word width.
- BURST_WORDS, 16, data words per command.

Ports:
- cpu_clk  in  1  clock; all logic on the rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request; held until burst done.
- req_cmd  in  NUM_REQ  per-requester command, 1=write, 0=read.
- req_ba  in  NUM_REQ*BA_W  packed bank addresses.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses.
- req_wr_data  in  NUM_REQ*DATA_W  packed current write words.
- grant  out  NUM_REQ  one-hot grant, registered.
- wr_data_ack  out  NUM_REQ  word consumed; requester advances to its next word.
- rd_valid  out  NUM_REQ  read word valid for the owning requester.
- rd_data  out  DATA_W  read word; shared by all requesters, qualified by rd_valid.
- addr_valid  out  1  command valid to the controller.
- cmd  out  1  latched command.
- ba  out  BA_W  latched bank address.
- addr  out  ADDR_W  latched address.
- wr_data  out  DATA_W  granted requester's req_wr_data.
- cmd_rdy  in  1  controller accepts the command when addr_valid && cmd_rdy.
- wr_data_valid  in  1  controller consumed one write word this cycle.
- ctl_rd_data  in  DATA_W  controller read word.
- ctl_rd_valid  in  1  controller read word valid.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, immediate): state=IDLE; grant=0; addr_valid=0; cmd=0; ba=0; addr=0; word count=0; RR pointer=0; proto_err=0.
- Reset mid-burst aborts the burst with no completion. All outputs return to reset values.
- States:
  - IDLE: if |req at the edge, pick the winner, register grant (one-hot), latch cmd/ba/addr from the winner's slice, set addr_valid=1, and go to ISSUE. Latency from req sampled to grant/addr_valid is 1 cycle.
  - ISSUE: hold addr_valid and the latched fields stable until cmd_rdy=1. On that edge, clear addr_valid and go to WDATA (cmd=1) or RDATA (cmd=0).
  - WDATA: wr_data = req_wr_data slice of the granted requester (combinational mux). wr_data_ack[g] = wr_data_valid (combinational). Each wr_data_valid increments the count.
  - RDATA: rd_data = ctl_rd_data. rd_valid[g] = ctl_rd_valid (combinational). Each ctl_rd_valid increments the count.
  - Burst end: the edge on which the count reaches BURST_WORDS-1 and a valid occurs. On that edge, set count=0, grant=0, RR pointer=g+1 mod NUM_REQ, and go to IDLE.
- Timing: at least one IDLE bubble between bursts. Minimum burst occupancy is 1 (IDLE) + 1 (ISSUE) + BURST_WORDS cycles.
- Round-robin: search starts at the pointer and goes upward with wrap. The first asserted req wins. Every continuously asserting requester is served within NUM_REQ bursts.
- req and fields are sampled only in IDLE. Changes to req, req_cmd, req_ba, or req_addr after grant are ignored. Deasserting req mid-burst does not shorten the burst.
- Outside the granted data phase, wr_data_ack=0, rd_valid=0, and wr_data=0.
- Protocol errors: wr_data_valid outside WDATA, or ctl_rd_valid outside RDATA, sets proto_err, which stays set until reset. The stray pulse is otherwise ignored: no count, no ack.
- Count is $clog2(BURST_WORDS)+1 bits wide and never exceeds BURST_WORDS-1.

Decomposition:
- Package ddr3_mem_pkg:
  - arbiter state enum (ARB_IDLE, ARB_ISSUE, ARB_WDATA, ARB_RDATA);
  - CMD_WRITE=1 and CMD_READ=0;
  - BURST_WORDS=16 constant.
- Sub-module ddr3_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, index, any.
  - Reused by future bank schedulers.

Test Plan:
- Single write: req=01, req_cmd=1, addr=32765, ba=0; cmd_rdy at cycle 3; 16 wr_data_valid pulses -> grant=01 at cycle 1, addr=32765, wr_data_ack[0] pulses 16 times, grant=0 after the 16th pulse.
- Contention: req=11 held, alternating write/read -> grants in order 01, 10, 01, 10; each burst carries exactly 16 words; IDLE bubble between bursts.
- Read routing: req=10, req_cmd=0; 16 ctl_rd_valid pulses with data 0..15 -> rd_valid[1] only, rd_data 0..15 in order, rd_valid[0] always 0.
- Backpressure: cmd_rdy low for 5 cycles -> addr_valid high for 6 cycles with addr/ba/cmd stable; changing req_addr during the wait does not alter addr.
- Protocol error: wr_data_valid pulse in IDLE -> proto_err=1 and sticky; no ack, no count; next write burst still completes 16 words.
- Reset mid-burst: cpu_rst asserted after 7 write words -> grant, addr_valid and count cleared immediately (async); after release, req=01 restarts the burst from word 0 with pointer at 0.

Source files
------------

// File: rtl/ddr3_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ddr3_mem_pkg
// Brief    : Shared types and constants for the DDR3 command arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WDATA = 2'd2,
        ARB_RDATA = 2'd3
    } arb_state_t;

    localparam logic CMD_WRITE   = 1'b1;
    localparam logic CMD_READ    = 1'b0;
    localparam int   BURST_WORDS = 16;

    // Data phase that follows an accepted command of the given type
    function automatic arb_state_t data_state(input logic cmd);
        return (cmd == CMD_WRITE) ? ARB_WDATA : ARB_RDATA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: ddr3_cmd_arbiter_if
// Brief    : Requester-side and controller-side signals of the command
//            arbiter. master = arbiter, slave = requesters + controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr3_cmd_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 15,
    parameter int BA_W    = 3,
    parameter int DATA_W  = 64
);
    // requester side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_cmd;
    logic [NUM_REQ*BA_W-1:0]   req_ba;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wr_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        wr_data_ack;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    // controller side
    logic                      addr_valid;
    logic                      cmd;
    logic [BA_W-1:0]           ba;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      cmd_rdy;
    logic                      wr_data_valid;
    logic [DATA_W-1:0]         ctl_rd_data;
    logic                      ctl_rd_valid;
    logic                      proto_err;

    modport master (
        input  req, req_cmd, req_ba, req_addr, req_wr_data,
        input  cmd_rdy, wr_data_valid, ctl_rd_data, ctl_rd_valid,
        output grant, wr_data_ack, rd_valid, rd_data,
        output addr_valid, cmd, ba, addr, wr_data, proto_err
    );

    modport slave (
        output req, req_cmd, req_ba, req_addr, req_wr_data,
        output cmd_rdy, wr_data_valid, ctl_rd_data, ctl_rd_valid,
        input  grant, wr_data_ack, rd_valid, rd_data,
        input  addr_valid, cmd, ba, addr, wr_data, proto_err
    );

endinterface
`default_nettype wire

// File: rtl/ddr3_cmd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rr_pick
// Brief    : Combinational round-robin picker. Search starts at i_ptr and
//            walks upward with wrap; the first asserted request wins.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_onehot,
    output logic      [IDX_W-1:0]   o_idx,
    output logic                    o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic               w_hit;
    int                 w_off;
    int                 w_sel;

    // Rotate so bit 0 is the pointer position, take the lowest hit, unrotate
    always_comb begin
        w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
        w_hit = 1'b0;
        w_off = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_hit = 1'b1;
                w_off = i;
            end
        end
        w_sel = int'(i_ptr) + w_off;
        if (w_sel >= NUM_REQ) begin
            w_sel = w_sel - NUM_REQ;
        end
        o_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_onehot[k] = w_hit && (k == w_sel);
        end
        o_idx = IDX_W'(w_sel);
        o_any = w_hit;
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_cmd_arbiter
// Brief    : Round-robin arbiter sharing the controller command/data channel
//            between NUM_REQ sources; holds the grant for a whole burst.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_cmd_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 15,
    parameter int BA_W        = 3,
    parameter int DATA_W      = 64,
    parameter int BURST_WORDS = ddr3_mem_pkg::BURST_WORDS
) (
    input  wire logic          cpu_clk,
    input  wire logic          cpu_rst,
    ddr3_cmd_arbiter_if.master bus
);
    import ddr3_mem_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_WORDS) + 1;
    localparam logic [CNT_W-1:0] c_last_word = CNT_W'(BURST_WORDS - 1);
    localparam logic [IDX_W-1:0] c_idx_max   = IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_addr_valid;
    logic               r_cmd;
    logic [BA_W-1:0]    r_ba;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_proto_err;

    logic [NUM_REQ-1:0] w_win_oh;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_any;
    logic               w_beat;
    logic               w_stray;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [DATA_W-1:0]  w_wr_data;
    logic [NUM_REQ-1:0] w_wr_ack;
    logic [NUM_REQ-1:0] w_rd_valid;
    logic [DATA_W-1:0]  w_rd_data;

    // Winner of the round-robin search; only consumed while idle
    ddr3_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_win_any)
    );

    // A beat counts only in the matching data phase; anything else is stray
    assign w_beat  = ((r_state == ARB_WDATA) && bus.wr_data_valid) ||
                     ((r_state == ARB_RDATA) && bus.ctl_rd_valid);
    assign w_stray = ((r_state != ARB_WDATA) && bus.wr_data_valid) ||
                     ((r_state != ARB_RDATA) && bus.ctl_rd_valid);
    assign w_ptr_next = (r_gidx == c_idx_max) ? '0 : r_gidx + 1'b1;

    // Arbitration FSM with registered grant, command fields and error flag
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_ptr        <= '0;
            r_addr_valid <= 1'b0;
            r_cmd        <= CMD_READ;
            r_ba         <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_stray) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_any) begin
                        r_grant      <= w_win_oh;
                        r_gidx       <= w_win_idx;
                        r_cmd        <= bus.req_cmd[w_win_idx];
                        r_ba         <= bus.req_ba[int'(w_win_idx)*BA_W +: BA_W];
                        r_addr       <= bus.req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
                        r_addr_valid <= 1'b1;
                        r_state      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.cmd_rdy) begin
                        r_addr_valid <= 1'b0;
                        r_state      <= data_state(r_cmd);
                    end
                end
                ARB_WDATA, ARB_RDATA: begin
                    if (w_beat) begin
                        if (r_cnt == c_last_word) begin
                            r_cnt   <= '0;
                            r_grant <= '0;
                            r_ptr   <= w_ptr_next;
                            r_state <= ARB_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Data steering: only the granted requester sees acks/read strobes
    always_comb begin
        w_wr_data  = '0;
        w_wr_ack   = '0;
        w_rd_valid = '0;
        w_rd_data  = '0;
        if (r_state == ARB_WDATA) begin
            w_wr_data = bus.req_wr_data[int'(r_gidx)*DATA_W +: DATA_W];
            w_wr_ack  = r_grant & {NUM_REQ{bus.wr_data_valid}};
        end
        if (r_state == ARB_RDATA) begin
            w_rd_data  = bus.ctl_rd_data;
            w_rd_valid = r_grant & {NUM_REQ{bus.ctl_rd_valid}};
        end
    end

    assign bus.grant       = r_grant;
    assign bus.addr_valid  = r_addr_valid;
    assign bus.cmd         = r_cmd;
    assign bus.ba          = r_ba;
    assign bus.addr        = r_addr;
    assign bus.proto_err   = r_proto_err;
    assign bus.wr_data     = w_wr_data;
    assign bus.wr_data_ack = w_wr_ack;
    assign bus.rd_valid    = w_rd_valid;
    assign bus.rd_data     = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_cmd_arbiter
// Brief    : Self-checking bench for ddr3_cmd_arbiter with a scoreboard of
//            expected grants, write beats and read beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_cmd_arbiter;
    import ddr3_mem_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 15;
    localparam int BA_W    = 3;
    localparam int DATA_W  = 64;
    localparam int BW      = 16;

    typedef struct {
        logic [NUM_REQ-1:0] oh;
        logic               c;
        logic [BA_W-1:0]    ba;
        logic [ADDR_W-1:0]  addr;
    } gnt_t;

    typedef struct {
        logic [NUM_REQ-1:0] oh;
        logic [DATA_W-1:0]  data;
    } beat_t;

    logic cpu_clk = 1'b0;
    logic cpu_rst;
    always #5 cpu_clk = ~cpu_clk;

    ddr3_cmd_arbiter_if #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .BA_W (BA_W), .DATA_W (DATA_W)
    ) bus ();

    ddr3_cmd_arbiter #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .BA_W (BA_W), .DATA_W (DATA_W),
        .BURST_WORDS (BW)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    bit     exp_proto = 1'b0;
    int     wcnt [NUM_REQ];
    logic [NUM_REQ-1:0] prev_grant = '0;
    gnt_t   gnt_q [$];
    beat_t  wr_q  [$];
    beat_t  rd_q  [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wbase(input int i);
        return 64'hC0DE_0000_0000_0000 + (64'(i) << 40);
    endfunction

    // Each requester presents its current word; it advances on its ack
    always_comb begin
        bus.req_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_wr_data[i*DATA_W +: DATA_W] = wbase(i) + 64'(wcnt[i]);
        end
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) wcnt[i] = 0;
    end

    // Monitor: compare DUT outputs against the scoreboard between edges
    always begin
        gnt_t  g;
        beat_t b;
        @(negedge cpu_clk);
        #2;
        if (!cpu_rst) begin
            if (bus.grant != '0 && prev_grant == '0) begin
                if (gnt_q.size() == 0) begin
                    check_eq("grant_unexpected", 64'(bus.grant), 64'd0);
                end else begin
                    g = gnt_q.pop_front();
                    check_eq("grant", 64'(bus.grant), 64'(g.oh));
                    check_eq("grant_cmd", 64'(bus.cmd), 64'(g.c));
                    check_eq("grant_ba", 64'(bus.ba), 64'(g.ba));
                    check_eq("grant_addr", 64'(bus.addr), 64'(g.addr));
                    check_eq("grant_av", 64'(bus.addr_valid), 64'd1);
                    for (int i = 0; i < NUM_REQ; i++) if (bus.grant[i]) wcnt[i] = 0;
                end
            end
            if (bus.wr_data_ack != '0) begin
                if (wr_q.size() == 0) begin
                    check_eq("wr_ack_unexpected", 64'(bus.wr_data_ack), 64'd0);
                end else begin
                    b = wr_q.pop_front();
                    check_eq("wr_ack", 64'(bus.wr_data_ack), 64'(b.oh));
                    check_eq("wr_data", bus.wr_data, b.data);
                end
                for (int i = 0; i < NUM_REQ; i++) if (bus.wr_data_ack[i]) wcnt[i]++;
            end
            if (bus.rd_valid != '0) begin
                if (rd_q.size() == 0) begin
                    check_eq("rd_valid_unexpected", 64'(bus.rd_valid), 64'd0);
                end else begin
                    b = rd_q.pop_front();
                    check_eq("rd_valid", 64'(bus.rd_valid), 64'(b.oh));
                    check_eq("rd_data", bus.rd_data, b.data);
                end
            end
        end
        prev_grant = bus.grant;
    end

    task automatic set_req(input int i, input logic c, input logic [ADDR_W-1:0] a, input logic [BA_W-1:0] b);
        bus.req_cmd[i]                  = c;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_ba[i*BA_W +: BA_W]       = b;
    endtask

    task automatic next_cycle();
        @(negedge cpu_clk);
        #1;
    endtask

    // Serve one expected burst; caller has already driven req this cycle
    task automatic serve(input int g, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [BA_W-1:0] b, input int rdy_delay, input int n_words,
                         input bit scramble, input logic [63:0] rd_base);
        gnt_t  e;
        beat_t bt;
        int    lat;
        int    hi;
        e.oh = NUM_REQ'(1) << g;
        e.c = wr;
        e.ba = b;
        e.addr = a;
        gnt_q.push_back(e);
        lat = 0;
        do begin
            next_cycle();
            lat++;
        end while (!bus.addr_valid && lat < 10);
        if (!bus.addr_valid) begin
            check_eq("issue_timeout", 64'd0, 64'd1);
            return;
        end
        check_eq("grant_latency", 64'(lat), 64'd1);
        hi = 0;
        for (int k = 0; k <= rdy_delay; k++) begin
            check_eq("hold_addr", 64'(bus.addr), 64'(a));
            check_eq("hold_ba", 64'(bus.ba), 64'(b));
            check_eq("hold_cmd", 64'(bus.cmd), 64'(wr));
            if (bus.addr_valid) hi++;
            if (scramble && k == 1) begin
                bus.req_addr = ~bus.req_addr;
                bus.req_ba   = ~bus.req_ba;
                bus.req_cmd  = ~bus.req_cmd;
            end
            bus.cmd_rdy = (k == rdy_delay);
            next_cycle();
        end
        bus.cmd_rdy = 1'b0;
        check_eq("addr_valid_cycles", 64'(hi), 64'(rdy_delay + 1));
        check_eq("addr_valid_clear", 64'(bus.addr_valid), 64'd0);
        for (int w = 0; w < n_words; w++) begin
            if (w % 5 == 4) begin
                bus.wr_data_valid = 1'b0;
                bus.ctl_rd_valid  = 1'b0;
                next_cycle();
            end
            bt.oh = NUM_REQ'(1) << g;
            if (wr) begin
                bus.wr_data_valid = 1'b1;
                bt.data = wbase(g) + 64'(w);
                wr_q.push_back(bt);
            end else begin
                bus.ctl_rd_valid = 1'b1;
                bus.ctl_rd_data  = rd_base + 64'(w);
                bt.data = rd_base + 64'(w);
                rd_q.push_back(bt);
            end
            next_cycle();
        end
        bus.wr_data_valid = 1'b0;
        bus.ctl_rd_valid  = 1'b0;
        if (n_words == BW) begin
            check_eq("burst_release", 64'(bus.grant), 64'd0);
            check_eq("idle_wr_data", bus.wr_data, 64'd0);
            check_eq("wr_q_drained", 64'(wr_q.size()), 64'd0);
            check_eq("rd_q_drained", 64'(rd_q.size()), 64'd0);
            check_eq("proto_err", 64'(bus.proto_err), 64'(exp_proto));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst           = 1'b1;
        bus.req           = '0;
        bus.req_cmd       = '0;
        bus.req_ba        = '0;
        bus.req_addr      = '0;
        bus.cmd_rdy       = 1'b0;
        bus.wr_data_valid = 1'b0;
        bus.ctl_rd_data   = '0;
        bus.ctl_rd_valid  = 1'b0;

        // reset state
        next_cycle();
        check_eq("rst_grant", 64'(bus.grant), 64'd0);
        check_eq("rst_addr_valid", 64'(bus.addr_valid), 64'd0);
        check_eq("rst_cmd", 64'(bus.cmd), 64'd0);
        check_eq("rst_ba", 64'(bus.ba), 64'd0);
        check_eq("rst_addr", 64'(bus.addr), 64'd0);
        check_eq("rst_proto_err", 64'(bus.proto_err), 64'd0);
        check_eq("rst_wr_data", bus.wr_data, 64'd0);
        check_eq("rst_acks", 64'({bus.wr_data_ack, bus.rd_valid}), 64'd0);
        next_cycle();
        cpu_rst = 1'b0;
        next_cycle();
        check_eq("idle_no_req", 64'(bus.grant), 64'd0);

        // single write from requester 0, cmd_rdy at cycle 3
        set_req(0, CMD_WRITE, 15'd32765, 3'd0);
        bus.req = 2'b01;
        serve(0, CMD_WRITE, 15'd32765, 3'd0, 2, BW, 1'b0, 64'd0);
        bus.req = 2'b00;

        // read routed to requester 1 only
        set_req(1, CMD_READ, 15'h1234, 3'd5);
        bus.req = 2'b10;
        serve(1, CMD_READ, 15'h1234, 3'd5, 0, BW, 1'b0, 64'd0);
        bus.req = 2'b00;

        // contention: both held, alternating write/read
        set_req(0, CMD_WRITE, 15'd100, 3'd1);
        set_req(1, CMD_READ, 15'd200, 3'd2);
        bus.req = 2'b11;
        for (int rep = 0; rep < 2; rep++) begin
            serve(0, CMD_WRITE, 15'd100, 3'd1, 1, BW, 1'b0, 64'd0);
            serve(1, CMD_READ, 15'd200, 3'd2, 0, BW, 1'b0, 64'h1000 * 64'(rep + 1));
        end
        bus.req = 2'b00;

        // backpressure with request fields changing during the wait
        set_req(0, CMD_WRITE, 15'h2AAA, 3'd6);
        bus.req = 2'b01;
        serve(0, CMD_WRITE, 15'h2AAA, 3'd6, 5, BW, 1'b1, 64'd0);
        bus.req = 2'b00;

        // stray write strobe while idle
        next_cycle();
        bus.wr_data_valid = 1'b1;
        exp_proto = 1'b1;
        next_cycle();
        bus.wr_data_valid = 1'b0;
        check_eq("proto_set", 64'(bus.proto_err), 64'd1);
        next_cycle();
        check_eq("proto_sticky", 64'(bus.proto_err), 64'd1);
        set_req(0, CMD_WRITE, 15'h0F0F, 3'd3);
        bus.req = 2'b01;
        serve(0, CMD_WRITE, 15'h0F0F, 3'd3, 0, BW, 1'b0, 64'd0);
        bus.req = 2'b00;

        // reset in the middle of a write burst
        set_req(0, CMD_WRITE, 15'h0555, 3'd7);
        bus.req = 2'b01;
        serve(0, CMD_WRITE, 15'h0555, 3'd7, 0, 7, 1'b0, 64'd0);
        #2;
        cpu_rst = 1'b1;
        #1;
        check_eq("async_rst_grant", 64'(bus.grant), 64'd0);
        check_eq("async_rst_av", 64'(bus.addr_valid), 64'd0);
        check_eq("async_rst_proto", 64'(bus.proto_err), 64'd0);
        exp_proto = 1'b0;
        next_cycle();
        cpu_rst = 1'b0;
        set_req(1, CMD_WRITE, 15'h0666, 3'd4);
        bus.req = 2'b11;
        serve(0, CMD_WRITE, 15'h0555, 3'd7, 0, BW, 1'b0, 64'd0);
        bus.req = 2'b00;

        next_cycle();
        next_cycle();
        check_eq("grant_q_drained", 64'(gnt_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
